// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: hazard and handshake inputs from the datapath,
// stall/flush/redirect controls back to it.
interface pipeline_ctrl_if;
    logic        decode_wait;
    logic        iresp_data_ok;
    logic        dreq_valid;
    logic        dresp_data_ok;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        stall_m;
    logic        flush_d;
    logic        flush_e;
    logic        flush_w;
    logic        inst_valid;
    logic        npc_sel;
    logic [63:0] npc_redirect;
    logic [31:0] stall_cycles;

    // Datapath side: raises hazards, obeys stall/flush controls.
    modport master (
        output decode_wait, iresp_data_ok, dreq_valid, dresp_data_ok,
               redirect, redirect_pc,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               inst_valid, npc_sel, npc_redirect, stall_cycles
    );

    // Controller side.
    modport slave (
        input  decode_wait, iresp_data_ok, dreq_valid, dresp_data_ok,
               redirect, redirect_pc,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               inst_valid, npc_sel, npc_redirect, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: arbitrates memory stalls, branch redirects,
// load-use hazards and instruction-fetch latency into stall/flush controls.
// Controls are combinational (same-cycle); only the fetch state, the
// pending-redirect latch and the stall counter are registered.
module pipeline_ctrl (
    input  logic              clk,
    input  logic              reset,
    pipeline_ctrl_if.slave    bus
);

    typedef enum logic [0:0] {
        F_REQ  = 1'b0,   // useful fetch in flight
        F_DROP = 1'b1    // stale fetch in flight, its response is discarded
    } fetch_state_e;

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;

    logic        rd_pend_r;
    logic [63:0] rd_pc_r;
    logic [31:0] stall_cycles_r;

    logic        mem_busy_s;
    logic        redirect_eff_s;
    logic        fetch_busy_s;
    logic        consume_s;

    logic        stall_f_s;
    logic        stall_d_s;
    logic        stall_e_s;
    logic        stall_m_s;
    logic        flush_d_s;
    logic        flush_e_s;
    logic        flush_w_s;
    logic        inst_valid_s;
    logic        npc_sel_s;
    logic [63:0] npc_redirect_s;

    // Hazard qualifiers; a redirect seen under a memory stall is deferred, not dropped.
    always_comb begin
        mem_busy_s     = bus.dreq_valid & ~bus.dresp_data_ok;
        redirect_eff_s = (bus.redirect | rd_pend_r) & ~mem_busy_s;
        fetch_busy_s   = ((state_r == F_REQ) & ~bus.iresp_data_ok) | (state_r == F_DROP);
        // The PC only takes the target once no fetch is outstanding.
        consume_s      = redirect_eff_s & ~fetch_busy_s;
    end

    // Prioritised stall/flush/redirect decode: mem_busy > redirect > decode_wait > fetch.
    always_comb begin
        stall_f_s      = 1'b0;
        stall_d_s      = 1'b0;
        stall_e_s      = 1'b0;
        stall_m_s      = 1'b0;
        flush_d_s      = 1'b0;
        flush_e_s      = 1'b0;
        flush_w_s      = 1'b0;
        inst_valid_s   = 1'b0;
        npc_sel_s      = 1'b0;
        npc_redirect_s = 64'h0;
        if (reset) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (mem_busy_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (redirect_eff_s) begin
            flush_d_s      = 1'b1;
            flush_e_s      = 1'b1;
            stall_f_s      = fetch_busy_s;
            npc_sel_s      = ~fetch_busy_s;
            npc_redirect_s = rd_pend_r ? rd_pc_r : bus.redirect_pc;
        end else if (bus.decode_wait) begin
            // A word arriving now is re-presented by the fetch unit later.
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (fetch_busy_s) begin
            stall_f_s = 1'b1;
            flush_d_s = 1'b1;
        end else begin
            inst_valid_s = 1'b1;
        end
    end

    // Fetch FSM next state: a redirect with a fetch still outstanding makes that fetch stale.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            F_REQ: begin
                if (redirect_eff_s && !bus.iresp_data_ok) begin
                    state_nxt_s = F_DROP;
                end else begin
                    state_nxt_s = F_REQ;
                end
            end
            F_DROP: begin
                if (bus.iresp_data_ok) begin
                    state_nxt_s = F_REQ;
                end else begin
                    state_nxt_s = F_DROP;
                end
            end
            default: state_nxt_s = F_REQ;
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= F_REQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pending-redirect latch: holds an unconsumed target until the PC takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_r <= 1'b0;
            rd_pc_r   <= 64'h0;
        end else if (consume_s) begin
            rd_pend_r <= 1'b0;
        end else if (bus.redirect) begin
            rd_pend_r <= 1'b1;
            rd_pc_r   <= bus.redirect_pc;
        end else begin
            rd_pend_r <= rd_pend_r;
        end
    end

    // Saturating count of decode-stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r <= 32'h0;
        end else if (stall_d_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign bus.stall_f      = stall_f_s;
    assign bus.stall_d      = stall_d_s;
    assign bus.stall_e      = stall_e_s;
    assign bus.stall_m      = stall_m_s;
    assign bus.flush_d      = flush_d_s;
    assign bus.flush_e      = flush_e_s;
    assign bus.flush_w      = flush_w_s;
    assign bus.inst_valid   = inst_valid_s;
    assign bus.npc_sel      = npc_sel_s;
    assign bus.npc_redirect = npc_redirect_s;
    assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port decode_wait  in  1  load-use or RAW hazard from the operand-forward unit.
REQ-004 SHALL have port iresp_data_ok  in  1  instruction-bus response valid, one cycle per request.
REQ-005 SHALL have port dreq_valid  in  1  memory-stage data request outstanding.
REQ-006 SHALL have port dresp_data_ok  in  1  data-bus response valid.
REQ-007 SHALL have port redirect  in  1  execute stage resolved a taken branch/jump.
REQ-008 SHALL have port redirect_pc  in  64  target of redirect.
REQ-009 SHALL have port stall_f, stall_d, stall_e, stall_m  out  1 each  hold the PC, F/D, D/E, E/M registers.
REQ-010 SHALL have port flush_d, flush_e, flush_w  out  1 each  load a bubble into F/D, D/E, M/W.
REQ-011 SHALL have port inst_valid  out  1  fetched word is accepted into F/D this cycle.
REQ-012 SHALL have port npc_sel  out  1  PC takes npc_redirect instead of sequential PC.
REQ-013 SHALL have port npc_redirect  out  64  redirect target for PC.
REQ-014 SHALL have port stall_cycles  out  32  saturating count of cycles with stall_d=1.

Function
REQ-015 SHALL define mem_busy = dreq_valid & ~dresp_data_ok.
REQ-016 SHALL implement fetch FSM states F_REQ (useful fetch in flight) and F_DROP (stale fetch in flight, response to be discarded).
REQ-017 SHALL transition F_REQ->F_DROP when redirect_eff=1 and iresp_data_ok=0; otherwise stay F_REQ.
REQ-018 SHALL transition F_DROP->F_REQ when iresp_data_ok=1; otherwise stay F_DROP.
REQ-019 SHALL define redirect_eff = (redirect | rd_pend) & ~mem_busy; redirect sampled while mem_busy=1 is latched into rd_pend/rd_pc, never lost.
REQ-020 SHALL hold rd_pend=1 and rd_pc from the first cycle a redirect is not consumed until a cycle with stall_f=0 consumes it; a new redirect while rd_pend=1 overwrites rd_pc (youngest execute result wins only if execute advanced; execute is stalled otherwise, so value is identical).
REQ-021 SHALL set fetch_busy = (state==F_REQ & ~iresp_data_ok) | state==F_DROP.
REQ-022 SHALL apply priority per cycle: mem_busy > redirect_eff > decode_wait > fetch_busy.
REQ-023 mem_busy: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, all other flushes 0.
REQ-024 redirect_eff (no mem_busy): flush_d=flush_e=1; stall_f=fetch_busy; npc_sel=~fetch_busy; npc_redirect = rd_pend ? rd_pc : redirect_pc; redirect consumed only when npc_sel=1.
REQ-025 decode_wait: stall_f=stall_d=1, flush_e=1.
REQ-026 fetch_busy only: stall_f=1, flush_d=1.
REQ-027 SHALL drive inst_valid = state==F_REQ & iresp_data_ok & ~redirect_eff & ~mem_busy & ~decode_wait.
REQ-028 SHALL, when iresp_data_ok arrives while stall_d=1 (mem_busy or decode_wait), keep stall_f=1 and the fetch stays F_REQ; fetch unit re-presents the same word (response held externally).
REQ-029 SHALL keep all outputs combinational from inputs and state, zero latency; only state, rd_pend, rd_pc, stall_cycles are registered.
REQ-030 SHALL increment stall_cycles when stall_d=1, saturating at 0xFFFF_FFFF.
REQ-031 SHALL, with all inputs idle and state F_REQ with iresp_data_ok=1, assert no stall or flush.

Reset
REQ-032 SHALL on reset=1 at a clock edge set state=F_REQ, rd_pend=0, rd_pc=0, stall_cycles=0.
REQ-033 SHALL during reset drive stall_*=0, flush_d=flush_e=flush_w=1, inst_valid=0, npc_sel=0, npc_redirect=0.
REQ-034 SHALL abandon any F_DROP or pending redirect on reset mid-operation with no residual effect next cycle.

Verification
REQ-035 Load-use: decode_wait=1 for 1 cycle, iresp_data_ok=1 -> stall_f=stall_d=1, flush_e=1, inst_valid=0, stall_cycles +1.
REQ-036 Memory miss: dreq_valid=1, dresp_data_ok=0 for 3 cycles, redirect=1 pc=0x8000_0040 in cycle 1 -> 3 cycles all stalls+flush_w; cycle 4 npc_sel=1, npc_redirect=0x8000_0040.
REQ-037 Redirect during fetch: state F_REQ, iresp_data_ok=0, redirect=1 pc=0x8000_0100 -> flush_d=flush_e=1, npc_sel=0, next state F_DROP; following data_ok dropped (inst_valid=0), then npc_sel=1 with 0x8000_0100.
REQ-038 Priority: mem_busy, redirect, decode_wait all 1 -> only mem_busy response (REQ-023).
REQ-039 Saturation: preload stall_cycles 0xFFFF_FFFE, 3 stalled cycles -> reads 0xFFFF_FFFF.
REQ-040 Reset in F_DROP with rd_pend=1 -> next cycle state F_REQ, npc_sel=0, stall_cycles=0.
